// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller for a classic 5-stage in-order pipeline.
//
// Decides each cycle which pipeline registers may load and which receive a NOP.
// It handles a slow data memory, a multi-cycle mul/div unit, branch mispredicts
// and load-use hazards. The outputs are Mealy: they are combinational from the
// state register and the current inputs.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   rs1_id, rs2_id            source registers of the instruction in ID
//   rd_ex, memread_ex         destination register of the EX instruction; EX is a load
//   mispredict_ex             branch resolved in EX disagrees with its prediction
//   dmem_req, dmem_ready      MEM-stage access valid; memory has completed it
//   mdu_start, mdu_done       multi-cycle op occupies EX; its result is valid
//   pc_write .. mem_wb_write  load enables for the PC and the pipeline registers
//   if_id_flush, id_ex_flush  load a NOP into IF/ID or ID/EX
//   ex_mem_bubble             load a NOP into EX/MEM
//   state_o                   0 = RUN, 1 = MEM_WAIT, 2 = MDU_BUSY
//   stall_cnt                 (only with STALL_CNT_EN) saturating count of cycles
//                             with pc_write low outside reset
//
// Configuration macro: STALL_CNT_EN adds the stall_cnt output and its counter.

module pipeline_stall_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic [4:0]  rd_ex,
  input  logic        memread_ex,
  input  logic        mispredict_ex,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  input  logic        mdu_start,
  input  logic        mdu_done,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        ex_mem_write,
  output logic        mem_wb_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_bubble,
  output logic [1:0]  state_o
`ifdef STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StMduBusy = 2'd2
  } state_e;

  state_e state_q, state_d;

  // {pc, if_id, id_ex, ex_mem, mem_wb}
  logic [4:0] wr;
  logic       mem_stall, mdu_stall, load_use;
  // Which parts of the normal RUN priority chain apply this cycle.
  logic       eval_en, en_mem, en_mdu;

  assign mem_stall = dmem_req & ~dmem_ready;
  assign mdu_stall = mdu_start & ~mdu_done;
  // x0 is hardwired to zero, so a load to it never creates a dependency.
  assign load_use  = memread_ex && (rd_ex != 5'd0) &&
                     ((rd_ex == rs1_id) || (rd_ex == rs2_id));

  always_comb begin
    wr            = 5'b11111;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    state_d       = state_q;
    eval_en       = 1'b0;
    en_mem        = 1'b0;
    en_mdu        = 1'b0;

    case (state_q)
      StRun: begin
        eval_en = 1'b1;
        en_mem  = 1'b1;
        en_mdu  = 1'b1;
      end
      StMemWait: begin
        if (dmem_ready) begin
          eval_en = 1'b1;
          en_mdu  = 1'b1;
          state_d = StRun;
        end else begin
          wr = 5'b00000;
        end
      end
      StMduBusy: begin
        if (mdu_done) begin
          eval_en = 1'b1;
          en_mem  = 1'b1;
          state_d = StRun;
        end else begin
          wr            = 5'b00011;
          ex_mem_bubble = 1'b1;
          // A slow memory access behind the MDU freezes the back end as well.
          if (mem_stall) wr = 5'b00000;
        end
      end
      default: state_d = StRun;
    endcase

    if (eval_en) begin
      if (en_mem && mem_stall) begin
        wr = 5'b00000;
        if (state_q == StRun) state_d = StMemWait;
      end else if (en_mdu && mdu_stall) begin
        wr            = 5'b00011;
        ex_mem_bubble = 1'b1;
        if (state_q == StRun) state_d = StMduBusy;
      end else if (mispredict_ex) begin
        // PC and IF/ID stay enabled so the redirect target is fetched.
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        wr[4]       = 1'b0;
        wr[3]       = 1'b0;
        id_ex_flush = 1'b1;
      end
    end

    if (rst) begin
      wr            = 5'b00000;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_bubble = 1'b0;
    end
  end

  assign {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = wr;
  assign state_o = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StRun;
    else     state_q <= state_d;
  end

`ifdef STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 32'd0;
    end else if (!pc_write && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: each stimulus cycle pushes its
// expected output vector, and a monitor on the falling edge pops and compares.

module tb_pipeline_stall_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_id, rs2_id, rd_ex;
  logic        memread_ex, mispredict_ex, dmem_req, dmem_ready, mdu_start, mdu_done;
  logic        pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic        if_id_flush, id_ex_flush, ex_mem_bubble;
  logic [1:0]  state_o;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  pipeline_stall_controller dut (
    .clk           (clk),
    .rst           (rst),
    .rs1_id        (rs1_id),
    .rs2_id        (rs2_id),
    .rd_ex         (rd_ex),
    .memread_ex    (memread_ex),
    .mispredict_ex (mispredict_ex),
    .dmem_req      (dmem_req),
    .dmem_ready    (dmem_ready),
    .mdu_start     (mdu_start),
    .mdu_done      (mdu_done),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .id_ex_write   (id_ex_write),
    .ex_mem_write  (ex_mem_write),
    .mem_wb_write  (mem_wb_write),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .ex_mem_bubble (ex_mem_bubble),
    .state_o       (state_o)
`ifdef STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       memread;
    logic       mispred;
    logic       dreq;
    logic       drdy;
    logic       mstart;
    logic       mdone;
  } stim_t;

  // Expected vector: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, bubble, state}
  localparam logic [9:0] ExpRst    = 10'b00000_000_00;
  localparam logic [9:0] ExpDef    = 10'b11111_000_00;
  localparam logic [9:0] ExpLu     = 10'b00111_010_00;
  localparam logic [9:0] ExpMisp   = 10'b11111_110_00;
  localparam logic [9:0] ExpMemRun = 10'b00000_000_00;
  localparam logic [9:0] ExpMemW   = 10'b00000_000_01;
  localparam logic [9:0] ExpMemRdy = 10'b11111_000_01;
  localparam logic [9:0] ExpMduRun = 10'b00011_001_00;
  localparam logic [9:0] ExpMduB   = 10'b00011_001_10;
  localparam logic [9:0] ExpMduMem = 10'b00000_001_10;
  localparam logic [9:0] ExpMduDn  = 10'b11111_000_10;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [9:0] exp_q[$];
  string      tag_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic stim_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic memread,
                               input logic mispred, input logic dreq, input logic drdy,
                               input logic mstart, input logic mdone);
    stim_t s;
    s = {rs1, rs2, rd, memread, mispred, dreq, drdy, mstart, mdone};
    return s;
  endfunction

  // Drive one cycle of stimulus just after the rising edge and queue its expectation.
  task automatic step(input string tag, input stim_t s, input logic [9:0] e);
    rs1_id        = s.rs1;
    rs2_id        = s.rs2;
    rd_ex         = s.rd;
    memread_ex    = s.memread;
    mispredict_ex = s.mispred;
    dmem_req      = s.dreq;
    dmem_ready    = s.drdy;
    mdu_start     = s.mstart;
    mdu_done      = s.mdone;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [9:0] e;
      string      t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, {22'd0, pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                if_id_flush, id_ex_flush, ex_mem_bubble, state_o}, {22'd0, e});
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t idle;
    idle = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    rs1_id = '0; rs2_id = '0; rd_ex = '0;
    memread_ex = 0; mispredict_ex = 0; dmem_req = 0; dmem_ready = 0;
    mdu_start = 0; mdu_done = 0;
    @(posedge clk);
    #1;
    step("reset", idle, ExpRst);
`ifdef STALL_CNT_EN
    check("cnt_reset", stall_cnt, 32'd0);
`endif
    rst = 1'b0;
    step("idle", idle, ExpDef);
    step("lu_rs2", mk(5'd1, 5'd5, 5'd5, 1, 0, 0, 0, 0, 0), ExpLu);
    step("after_lu", idle, ExpDef);
    step("lu_rs1", mk(5'd7, 5'd2, 5'd7, 1, 0, 0, 0, 0, 0), ExpLu);
    step("no_load", mk(5'd7, 5'd2, 5'd7, 0, 0, 0, 0, 0, 0), ExpDef);
    step("x0", mk(5'd0, 5'd3, 5'd0, 1, 0, 0, 0, 0, 0), ExpDef);
    step("misp_lu", mk(5'd1, 5'd5, 5'd5, 1, 1, 0, 0, 0, 0), ExpMisp);
    // Memory stall outranks a simultaneous mispredict.
    step("mem_c1", mk(5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0, 0), ExpMemRun);
    step("mem_c2", mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0), ExpMemW);
    step("mem_c3", mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0), ExpMemW);
    step("mem_rdy", mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0), ExpMemRdy);
    step("mem_back", idle, ExpDef);
`ifdef STALL_CNT_EN
    // Two load-use cycles plus three memory-stall cycles.
    check("cnt_stalls", stall_cnt, 32'd5);
`endif
    // MDU stall outranks a simultaneous mispredict.
    step("mdu_c1", mk(5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 1, 0), ExpMduRun);
    step("mdu_c2", mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0), ExpMduB);
    step("mdu_mem", mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1, 0), ExpMduMem);
    step("mdu_done", mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1), ExpMduDn);
    step("mdu_back", idle, ExpDef);
    step("mdu_nostall", mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1), ExpDef);
    step("mdu2_c1", mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0), ExpMduRun);
    step("mdu2_c2", mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0), ExpMduB);
    rst = 1'b1;
    step("mdu_rst", mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0), ExpRst);
    rst = 1'b0;
    step("after_mdu_rst", idle, ExpDef);
    step("mem2_c1", mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0), ExpMemRun);
    step("mem2_c2", mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0), ExpMemW);
    rst = 1'b1;
    step("mem_rst", mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0), ExpRst);
    rst = 1'b0;
    step("after_mem_rst", idle, ExpDef);
`ifdef STALL_CNT_EN
    check("cnt_cleared", stall_cnt, 32'd0);
`endif
    repeat (3) @(posedge clk);
    check("drain", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have ports rs1_id and rs2_id, input, 5 bits each: source registers of the instruction in ID.
REQ-004 SHALL have ports rd_ex (input, 5 bits) and memread_ex (input, 1 bit): destination register of the EX instruction, and a flag that it is a load.
REQ-005 SHALL have port mispredict_ex, input, 1 bit: branch resolved in EX disagrees with its prediction.
REQ-006 SHALL have ports dmem_req and dmem_ready, input, 1 bit each: MEM-stage access valid; memory done.
REQ-007 SHALL have ports mdu_start and mdu_done, input, 1 bit each: multi-cycle mul/div op in EX; result valid.
REQ-008 SHALL have ports pc_write, if_id_write, id_ex_write, ex_mem_write and mem_wb_write, output, 1 bit each: register enables.
REQ-009 SHALL have ports if_id_flush, id_ex_flush and ex_mem_bubble, output, 1 bit each: insert a NOP into that register.
REQ-010 SHALL have port state_o, output, 2 bits: RUN=0, MEM_WAIT=1, MDU_BUSY=2.

Function
REQ-011 Outputs SHALL be combinational from state and inputs (Mealy); the state SHALL be the only register, apart from REQ-023.
REQ-012 Default outputs SHALL be: all *_write=1, all flush/bubble=0.
REQ-013 Memory stall: in RUN, dmem_req=1 and dmem_ready=0 SHALL drive all *_write=0 and move to MEM_WAIT; this has the highest priority.
REQ-014 In MEM_WAIT, all *_write SHALL be 0 while dmem_ready=0; when dmem_ready=1, outputs SHALL follow RUN evaluation (REQ-015..018, excluding REQ-013), with next state RUN.
REQ-015 MDU stall: in RUN, mdu_start=1 and mdu_done=0 SHALL drive pc_write=if_id_write=id_ex_write=0 and ex_mem_bubble=1, with next state MDU_BUSY.
- mdu_start=1 together with mdu_done=1 SHALL cause no stall.
REQ-016 In MDU_BUSY, outputs SHALL match REQ-015 while mdu_done=0; a concurrent unready dmem_req SHALL force all *_write=0 and stay in MDU_BUSY.
- When mdu_done=1: outputs SHALL follow RUN evaluation with mdu_start ignored, and next state SHALL be RUN.
REQ-017 Mispredict: mispredict_ex=1 (no higher-priority condition) SHALL drive if_id_flush=1 and id_ex_flush=1, with pc_write=1 and if_id_write=1 so the redirect target loads; it takes priority over load-use.
REQ-018 Load-use: memread_ex=1, rd_ex!=0 and rd_ex equal to rs1_id or rs2_id SHALL drive pc_write=0, if_id_write=0 and id_ex_flush=1 for exactly one cycle; the state SHALL not change.
REQ-019 Priority SHALL be: memory stall > MDU stall > mispredict > load-use.
REQ-020 rd_ex=0 SHALL never trigger a load-use stall.

Reset
REQ-021 While rst=1: state SHALL be RUN, all *_write=0, all flush/bubble=0, state_o=0.
REQ-022 After rst deasserts, the first edge SHALL evaluate in RUN; asserting rst mid-MEM_WAIT or mid-MDU_BUSY SHALL abandon the stall immediately.

Configuration
REQ-023 With macro STALL_CNT_EN defined, SHALL add output stall_cnt (32 bits): counts cycles with pc_write=0 and rst=0, saturates at 0xFFFFFFFF, and is cleared to 0 by reset.
- Without STALL_CNT_EN, the port and counter SHALL be absent and behaviour SHALL be otherwise identical.

Verification
REQ-024 Load-use: memread_ex=1, rd_ex=5, rs2_id=5 -> one cycle of pc_write=0, if_id_write=0, id_ex_flush=1, then defaults.
REQ-025 Zero register: memread_ex=1, rd_ex=0, rs1_id=0 -> defaults, no stall.
REQ-026 Mispredict plus load-use in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_write=1.
REQ-027 dmem_req=1 with dmem_ready low for 3 cycles -> 3 cycles all *_write=0, state_o=1; ready cycle writes=1; then state_o=0; stall_cnt=3 if enabled.
REQ-028 mdu_start=1 with mdu_done on the 4th cycle -> 3 cycles ex_mem_bubble=1, mem_wb_write=1; rst pulse mid-sequence -> state_o=0 and all *_write=0 immediately.
